// File: rtl/ymdu.sv
// Iterative multiply/divide unit owning the HI/LO pair (mult/multu/div/divu, mthi/mtlo).
// Divider hardware is built only when YMDU_DIV_EN is defined.
module ymdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sgn;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_next;
    logic [AW-1:0]    step;
    logic [AW-1:0]    prod_fix;

`ifdef YMDU_DIV_EN
    logic             neg_a_q, neg_a_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [AW-1:0]    div_next;
    logic [WIDTH-1:0] quo_fix, rem_fix;
`endif

    always_comb begin
        sgn   = ~op[0];
        mag_a = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b = (sgn && b[WIDTH-1]) ? -b : b;

        // Shift-add: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, mc_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        step     = mul_next;
`ifdef YMDU_DIV_EN
        // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
        div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mc_q});
        div_diff  = div_shift[WIDTH-1:0] - mc_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        if (is_div_q) step = div_next;
        quo_fix   = neg_res_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem_fix   = neg_a_q ? -step[AW-1:WIDTH] : step[AW-1:WIDTH];
`endif
        prod_fix = neg_res_q ? -step : step;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
`ifdef YMDU_DIV_EN
        neg_a_d   = neg_a_q;
        bzero_d   = bzero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_BUSY;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                        mc_d  = mag_b;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                        mc_d  = mag_a;
                    end
`ifdef YMDU_DIV_EN
                    neg_a_d = sgn & a[WIDTH-1];
                    bzero_d = (b == '0);
`endif
                end else begin
                    if (wr_hi) hi_d = wd;
                    if (wr_lo) lo_d = wd;
                end
            end
            S_BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = prod_fix[AW-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
`ifdef YMDU_DIV_EN
                    else begin
                        // Zero divisor: remainder path already yields a; quotient forced to ones
                        hi_d = rem_fix;
                        lo_d = bzero_q ? '1 : quo_fix;
                        dz_d = bzero_q;
                    end
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mc_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef YMDU_DIV_EN
            neg_a_q   <= 1'b0;
            bzero_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef YMDU_DIV_EN
            neg_a_q   <= neg_a_d;
            bzero_q   <= bzero_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ymdu.sv
// Scoreboard bench for ymdu: directed mult/div vectors, HI/LO writes, latency and reset abort.
module tb_ymdu;

`ifdef YMDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t m;            // model of the architectural HI/LO/dz

    ymdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("result_dz", 32'(dz), 32'(e.dz));
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input bit wr_same, input bit wr_busy);
        exp_t        e;
        logic [31:0] old_lo;
        int          k;
        bit          seen;
        if (o[1] && !DIV_EN) e = m;
        else begin
            e.hi = ehi; e.lo = elo; e.dz = edz;
        end
        old_lo = m.lo;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (wr_same) begin wr_lo = 1'b1; wd = 32'hAAAA_AAAA; end
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0; a = $urandom; b = $urandom;
        k = 1; seen = 0;
        if (wr_same) check("start_wr_discard", lo, old_lo);
        while (k < 60 && !seen) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                k++;
                if (wr_busy && k == 3) begin wr_lo = 1'b1; wd = 32'h5555_5555; end
                if (wr_busy && k == 4) begin wr_lo = 1'b0; check("busy_wr_ignored", lo, old_lo); end
            end
        end
        check("done_latency", 32'(k), 32'd33);
        m = e;
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int  k;
        bit  seen;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
        m.hi = '0; m.lo = '0; m.dz = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(dz), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // mthi in IDLE
        wr_hi = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi", hi, 32'hDEAD_BEEF);
        m.hi = 32'hDEAD_BEEF;

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);
        do_op(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0, 0);
        check("dz_level", 32'(dz), 32'(m.dz));
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0);
        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, m.dz, 0, 0);
        do_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, m.dz, 0, 1);
        do_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, m.dz, 1, 0);

        // mthi + mtlo together
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h0BAD_F00D;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("both_wr_hi", hi, 32'h0BAD_F00D);
        check("both_wr_lo", lo, 32'h0BAD_F00D);

        // Abort: second start ignored, reset mid-operation, no done afterwards
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k < 11; k++) begin
            if (k == 5) begin start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; end
            if (k == 6) start = 1'b0;
            if (k == 10) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_dz", 32'(dz), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
